// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scan driver with dead time, blanking and
// frame-coherent input snapshot.
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEAD_CYCLES    = 2,
  parameter int unsigned DECODE         = 1,
  parameter int unsigned SEL_ACTIVE_LOW = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  localparam int unsigned IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [7*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   x,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [7*NUM_DIGITS-1:0] r_snap;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic                    r_started;

  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [7*NUM_DIGITS-1:0] w_snap_nxt;
  logic [NUM_DIGITS-1:0]   w_blank_nxt;
  logic                    w_started_nxt;
  logic                    w_tick_nxt;
  logic [6:0]              w_slot;
  logic [6:0]              w_pat;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS-1:0]   w_x_nxt;
  logic [6:0]              w_seg_nxt;
  int unsigned             w_base;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Prescaler / slot advance / frame-start snapshot; the first enabled
  // cycle after reset opens frame 0 without advancing the prescaler.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_snap_nxt    = r_snap;
    w_blank_nxt   = r_blank;
    w_started_nxt = r_started;
    w_tick_nxt    = 1'b0;
    if (enable) begin
      if (!r_started) begin
        w_started_nxt = 1'b1;
        w_tick_nxt    = 1'b1;
        w_snap_nxt    = digit_data;
        w_blank_nxt   = blank_mask;
      end else if (r_cnt == CNT_LAST) begin
        w_cnt_nxt = '0;
        if (r_idx == IDX_LAST) begin
          w_idx_nxt   = '0;
          w_tick_nxt  = 1'b1;
          w_snap_nxt  = digit_data;
          w_blank_nxt = blank_mask;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // Output pattern for the post-update slot position.
  always_comb begin
    w_base    = 32'(w_idx_nxt) * 32'd7;
    w_slot    = w_snap_nxt[w_base +: 7];
    w_pat     = (DECODE != 0) ? hex7(w_slot[3:0]) : w_slot;
    w_lit     = enable && (32'(w_cnt_nxt) >= DEAD_CYCLES) && !w_blank_nxt[w_idx_nxt];
    w_onehot  = NUM_DIGITS'(1) << w_idx_nxt;
    w_x_nxt   = w_lit ? (w_onehot ^ SEL_OFF) : SEL_OFF;
    w_seg_nxt = (w_lit ? w_pat : 7'h00) ^ SEG_MASK;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_snap     <= '0;
      r_blank    <= '0;
      r_started  <= 1'b0;
      x          <= SEL_OFF;
      seg        <= SEG_MASK;
      frame_tick <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_snap     <= w_snap_nxt;
      r_blank    <= w_blank_nxt;
      r_started  <= w_started_nxt;
      x          <= w_x_nxt;
      seg        <= w_seg_nxt;
      frame_tick <= w_tick_nxt;
    end
  end

  assign digit_idx = r_idx;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: hex decode build plus a raw/inverted build.
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [6:0] d [4];
  logic [3:0] blank;
  logic [27:0] digit_data;
  logic [6:0] seg;
  logic [3:0] x;
  logic [1:0] digit_idx;
  logic       frame_tick;

  logic [27:0] d2_data;
  logic [3:0]  d2_blank;
  logic [6:0]  seg2;
  logic [3:0]  x2;
  logic [1:0]  idx2;
  logic        tick2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign digit_data = {d[3], d[2], d[1], d[0]};
  assign d2_data    = {7'h7F, 7'h00, 7'h12, 7'h49};
  assign d2_blank   = 4'b0100;

  seg_scan_mux #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(1),
    .DECODE(1), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .digit_data(digit_data), .blank_mask(blank),
    .seg(seg), .x(x), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  seg_scan_mux #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(0),
    .DECODE(0), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .digit_data(d2_data), .blank_mask(d2_blank),
    .seg(seg2), .x(x2), .digit_idx(idx2), .frame_tick(tick2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock of the decode build, then check all outputs.
  task automatic cyc(input logic [1:0] ei, input logic [3:0] ex, input logic [6:0] es, input logic et);
    step();
    chk("idx", 32'(digit_idx), 32'(ei));
    chk("x", 32'(x), 32'(ex));
    chk("seg", 32'(seg), 32'(es));
    chk("tick", 32'(frame_tick), 32'(et));
  endtask

  // One 4-cycle slot of the decode build: one dead cycle, three lit cycles.
  task automatic slot(input logic [1:0] s, input logic [3:0] xe, input logic [6:0] se, input logic tk);
    cyc(s, 4'hF, 7'h00, tk);
    repeat (3) cyc(s, xe, se, 1'b0);
  endtask

  // One clock of the raw/inverted build.
  task automatic cyc2(input logic [1:0] ei, input logic [3:0] ex, input logic [6:0] es, input logic et);
    step();
    chk("idx2", 32'(idx2), 32'(ei));
    chk("x2", 32'(x2), 32'(ex));
    chk("seg2", 32'(seg2), 32'(es));
    chk("tick2", 32'(tick2), 32'(et));
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    d[0] = 7'h00; d[1] = 7'h0F; d[2] = 7'h02; d[3] = 7'h08;
    blank = 4'b0000;

    // Reset state, then released but not yet enabled: stays dark, no tick
    cyc(2'd0, 4'hF, 7'h00, 1'b0);
    rst_n = 1'b1;
    cyc(2'd0, 4'hF, 7'h00, 1'b0);

    // Basic scan: digits 8,2,F,0
    enable = 1'b1;
    slot(2'd0, 4'b1110, 7'h3F, 1'b1);
    slot(2'd1, 4'b1101, 7'h71, 1'b0);
    slot(2'd2, 4'b1011, 7'h5B, 1'b0);
    slot(2'd3, 4'b0111, 7'h7F, 1'b0);

    // Second frame; mid-frame change of digits 0 and 3 while idx=2
    slot(2'd0, 4'b1110, 7'h3F, 1'b1);
    slot(2'd1, 4'b1101, 7'h71, 1'b0);
    slot(2'd2, 4'b1011, 7'h5B, 1'b0);
    d[0] = 7'h05;
    d[3] = 7'h01;
    slot(2'd3, 4'b0111, 7'h7F, 1'b0);

    // Blank digit 1 at a frame start; clearing mid-frame has no effect yet
    blank = 4'b0010;
    slot(2'd0, 4'b1110, 7'h6D, 1'b1);
    blank = 4'b0000;
    slot(2'd1, 4'hF, 7'h00, 1'b0);
    slot(2'd2, 4'b1011, 7'h5B, 1'b0);
    slot(2'd3, 4'b0111, 7'h06, 1'b0);

    // Next frame: blank cleared; disable at cnt=2 of slot 2
    slot(2'd0, 4'b1110, 7'h6D, 1'b1);
    slot(2'd1, 4'b1101, 7'h71, 1'b0);
    cyc(2'd2, 4'hF, 7'h00, 1'b0);
    cyc(2'd2, 4'b1011, 7'h5B, 1'b0);
    cyc(2'd2, 4'b1011, 7'h5B, 1'b0);
    enable = 1'b0;
    repeat (5) cyc(2'd2, 4'hF, 7'h00, 1'b0);
    enable = 1'b1;
    cyc(2'd2, 4'b1011, 7'h5B, 1'b0);
    cyc(2'd3, 4'hF, 7'h00, 1'b0);
    cyc(2'd3, 4'b0111, 7'h06, 1'b0);

    // Reset mid slot 3 with enable high; fresh snapshot on release
    rst_n = 1'b0;
    d[0] = 7'h0A;
    cyc(2'd0, 4'hF, 7'h00, 1'b0);
    cyc(2'd0, 4'hF, 7'h00, 1'b0);
    rst_n = 1'b1;
    slot(2'd0, 4'b1110, 7'h77, 1'b1);
    slot(2'd1, 4'b1101, 7'h71, 1'b0);

    // Raw, inverted segments, no dead time, digit 2 blanked
    rst_n = 1'b0;
    cyc2(2'd0, 4'hF, 7'h7F, 1'b0);
    rst_n = 1'b1;
    cyc2(2'd0, 4'b1110, 7'h36, 1'b1);
    repeat (3) cyc2(2'd0, 4'b1110, 7'h36, 1'b0);
    repeat (4) cyc2(2'd1, 4'b1101, 7'h6D, 1'b0);
    repeat (4) cyc2(2'd2, 4'hF, 7'h7F, 1'b0);
    repeat (4) cyc2(2'd3, 4'b0111, 7'h00, 1'b0);
    cyc2(2'd0, 4'b1110, 7'h36, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
